md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
// Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline; owns HI/LO.
// Executes mult/multu/div/divu over a fixed multi-cycle latency, plus mthi/mtlo writes.
// Drives start/busy upstream into the hazard/stall logic. That logic holds any md-class
// instruction in ID while (start || busy).
// Exposes HI/LO so EX can forward them for mfhi/mflo.
// PARAMETERS
// MULT_CYCLES  5   busy cycles after a mult/multu issue (>=1)
// DIV_CYCLES   10  busy cycles after a div/divu issue (>=1)
// PORTS
// clk      in   1   rising-edge clock
// reset    in   1   asynchronous, active-high; clears all state
// md_op    in   4   decoded op of the instruction currently in EX (MD_NONE..MD_MTLO)
// rs_val   in   32  forwarded rs operand
// rt_val   in   32  forwarded rt operand
// flush    in   1   exception/interrupt taken this cycle; cancels the EX-stage md op
// start    out  1   combinational: md_op in {MULT,MULTU,DIV,DIVU} && !flush && !busy
// busy     out  1   registered: operation in flight
// hi       out  32  HI register (registered)
// lo       out  32  LO register (registered)
// BEHAVIOUR
// - Reset (async, active-high): hi=0, lo=0, busy=0, cnt=0, state=IDLE, pend_hi/pend_lo=0.
//   Reset mid-operation aborts the op; HI/LO stay 0.
// - FSM states: IDLE, RUN.
//   IDLE -> RUN on start.
//   RUN -> IDLE on the edge where cnt==1.
// - Issue, cycle T (start=1):
//   - compute the 64-bit result from rs_val/rt_val into pend_hi/pend_lo;
//   - load cnt = MULT_CYCLES or DIV_CYCLES.
// - busy=1 in cycles T+1..T+N. At the edge ending T+N: hi<=pend_hi, lo<=pend_lo, busy<=0.
//   New HI/LO values are visible from T+N+1.
// - mult:  {hi,lo} = $signed(rs)*$signed(rt).  multu: unsigned 32x32->64.
// - div:   lo = signed quotient, hi = signed remainder.
//   The remainder takes the sign of the dividend (truncating division).
// - divu:  unsigned quotient/remainder.
// - Divide by zero: op runs full DIV_CYCLES with busy as normal; HI/LO left unchanged at completion.
// - 0x80000000 / -1 (div): lo=0x80000000, hi=0.
// - mthi/mtlo: write hi/lo <= rs_val at the end of the EX cycle, only if !flush && !busy.
//   Not multi-cycle; start stays 0.
// - flush:
//   - forces start=0 and suppresses mthi/mtlo in that cycle;
//   - does NOT abort an op already in RUN, since its instruction has committed.
// - md op presented while busy: ignored (stall logic prevents this; the bench asserts it never occurs).
// - hi/lo hold their old values throughout RUN, so mfhi/mflo must be stalled by the stall logic.
// STRUCTURE
// - Shared header md_def.vh holds:
//   - md_op encodings: MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO;
//   - FSM state constants;
//   - default latency values.
// - Decoder in EX maps the instruction word to md_op.
// - One sub-module: md_calc (pure combinational, 64-bit result for the 4 arithmetic ops,
//   including the divide-by-zero hold flag). The FSM/counter/HI-LO registers live in md_unit.
// TESTING
// 1. mult rs=0xFFFFFFFE (-2), rt=3 -> start=1 one cycle; busy=1 for 5 cycles;
//    then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
// 2. multu rs=0xFFFFFFFF, rt=2 -> after 5 busy cycles: hi=0x00000001, lo=0xFFFFFFFE.
// 3. div rs=-7, rt=2 -> busy 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//    divu 7/0 -> busy 10 cycles, hi/lo unchanged.
// 4. div issued with flush=1 in the same cycle -> start=0, busy stays 0, hi/lo unchanged.
//    flush=1 on the 3rd busy cycle of a mult -> op completes normally.
// 5. mthi rs=0x12345678 -> hi=0x12345678 next cycle, busy=0.
//    mtlo with flush=1 -> lo unchanged.
// 6. reset asserted asynchronously mid-div (cycle 4 of 10) -> busy, hi, lo drop to 0
//    immediately, without waiting for a clock edge; the next mult after release works normally.

Source files
------------

// File: rtl/md_unit_pkg.sv
// ------------------------------------------------------------------
// md_unit_pkg : shared encodings, FSM states and latencies for md_unit
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package md_unit_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  function automatic logic md_is_mult(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic md_is_arith(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_unit_calc.sv
// ------------------------------------------------------------------
// md_unit_calc : combinational 64-bit {hi,lo} result for mult/multu/div/divu
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module md_unit_calc
  import md_unit_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] res_o,
  output logic        div0_o
);

  logic signed [63:0] a_s64;
  logic signed [63:0] b_s64;
  logic signed [32:0] a_s33;
  logic signed [32:0] b_s33;
  logic        [31:0] b_nz;

  // 33-bit signed divide keeps 0x80000000 / -1 representable; truncation gives lo=0x80000000.
  always_comb begin
    a_s64  = $signed({{32{a_i[31]}}, a_i});
    b_s64  = $signed({{32{b_i[31]}}, b_i});
    a_s33  = $signed({a_i[31], a_i});
    b_s33  = (b_i == 32'd0) ? 33'sd1 : $signed({b_i[31], b_i});
    b_nz   = (b_i == 32'd0) ? 32'd1 : b_i;
    res_o  = 64'd0;
    div0_o = 1'b0;
    case (op_i)
      MD_MULT:  res_o = a_s64 * b_s64;
      MD_MULTU: res_o = {32'd0, a_i} * {32'd0, b_i};
      MD_DIV: begin
        res_o  = {32'(a_s33 % b_s33), 32'(a_s33 / b_s33)};
        div0_o = (b_i == 32'd0);
      end
      MD_DIVU: begin
        res_o  = {a_i % b_nz, a_i / b_nz};
        div0_o = (b_i == 32'd0);
      end
      default: res_o = 64'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/md_unit.sv
// ------------------------------------------------------------------
// md_unit : MIPS EX-stage multiply/divide unit owning HI/LO
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_hold_q, pend_hold_d;

  logic [63:0]      calc_res;
  logic             calc_div0;

  md_unit_calc u_calc (
    .op_i   (md_op),
    .a_i    (rs_val),
    .b_i    (rt_val),
    .res_o  (calc_res),
    .div0_o (calc_div0)
  );

  assign start = md_is_arith(md_op) && !flush && (state_q == S_IDLE);
  assign busy  = (state_q == S_RUN);
  assign hi    = hi_q;
  assign lo    = lo_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    pend_hi_d   = pend_hi_q;
    pend_lo_d   = pend_lo_q;
    pend_hold_d = pend_hold_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d                = S_RUN;
          cnt_d                  = md_is_mult(md_op) ? CNT_MULT : CNT_DIV;
          {pend_hi_d, pend_lo_d} = calc_res;
          pend_hold_d            = calc_div0;
        end else if (!flush && (md_op == MD_MTHI)) begin
          hi_d = rs_val;
        end else if (!flush && (md_op == MD_MTLO)) begin
          lo_d = rs_val;
        end
      end
      S_RUN: begin
        // Flush is ignored here: the owning instruction has already committed.
        if (cnt_q == CNT_ONE) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (!pend_hold_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      pend_hi_q   <= 32'd0;
      pend_lo_q   <= 32'd0;
      pend_hold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      pend_hi_q   <= pend_hi_d;
      pend_lo_q   <= pend_lo_d;
      pend_hold_q <= pend_hold_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ------------------------------------------------------------------
// tb_md_unit : self-checking bench for md_unit against a cycle-level reference model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_md_unit;
  import md_unit_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  md_op = MD_NONE;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        flush = 1'b0;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: architectural HI/LO, remaining busy cycles, pending {hold,hi,lo}.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          m_rem = 0;
  logic [64:0] m_pend = 65'd0;

  md_unit #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .flush  (flush),
    .start  (start),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic is_arith(input logic [3:0] op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction

  // {div-by-zero hold, hi, lo} from plain 64-bit arithmetic.
  function automatic logic [64:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic        [63:0] ua, ub, uq, ur;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ref_result = 65'd0;
    case (op)
      MD_MULT:  ref_result = {1'b0, sa * sb};
      MD_MULTU: ref_result = {1'b0, ua * ub};
      MD_DIV: begin
        if (b == 32'd0) ref_result = {1'b1, 64'd0};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          ref_result = {1'b0, sr[31:0], sq[31:0]};
        end
      end
      MD_DIVU: begin
        if (b == 32'd0) ref_result = {1'b1, 64'd0};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          ref_result = {1'b0, ur[31:0], uq[31:0]};
        end
      end
      default: ref_result = 65'd0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
      m_rem  <= 0;
      m_pend <= 65'd0;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1 && !m_pend[64]) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
    end else if (!flush) begin
      if (is_arith(md_op)) begin
        m_pend <= ref_result(md_op, rs_val, rt_val);
        m_rem  <= (md_op == MD_MULT || md_op == MD_MULTU) ? MULT_N : DIV_N;
      end else if (md_op == MD_MTHI) begin
        m_hi <= rs_val;
      end else if (md_op == MD_MTLO) begin
        m_lo <= rs_val;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("start", {31'd0, start}, {31'd0, is_arith(md_op) && !flush && (m_rem == 0)});
      chk("busy", {31'd0, busy}, {31'd0, m_rem != 0});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      if (md_op != MD_NONE) chk("op_while_busy", {31'd0, busy}, 32'd0);
    end
  end

  task automatic wait_idle();
    int k;
    for (k = 0; k < 40; k++) begin
      if (m_rem == 0) break;
      @(posedge clk); #1;
    end
    if (k == 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: model still busy after %0d cycles", k);
    end
  endtask

  // Issue one op for a single cycle, report start during issue and the busy-cycle count.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic fl, output int nb, output logic st);
    wait_idle();
    @(posedge clk); #1;
    md_op = op; rs_val = a; rt_val = b; flush = fl;
    #3 st = start;
    @(posedge clk); #1;
    md_op = MD_NONE; flush = 1'b0;
    nb = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
    end
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int   nb;
    logic st;
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   nb;
    logic st;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, nb, st);
    chk("mult_start", {31'd0, st}, 32'd1);
    chk("mult_busy_cycles", nb, 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    chk("model_mult_hi", m_hi, 32'hFFFF_FFFF);

    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, nb, st);
    chk("multu_busy_cycles", nb, 32'd5);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, nb, st);
    chk("div_busy_cycles", nb, 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("model_div_lo", m_lo, 32'hFFFF_FFFD);

    run_op(MD_DIVU, 32'd7, 32'd0, 1'b0, nb, st);
    chk("divu0_busy_cycles", nb, 32'd10);
    chk("divu0_hi", hi, 32'hFFFF_FFFF);
    chk("divu0_lo", lo, 32'hFFFF_FFFD);

    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, nb, st);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'd0);

    run_op(MD_DIV, 32'd9, 32'd2, 1'b1, nb, st);
    chk("flush_start", {31'd0, st}, 32'd0);
    chk("flush_busy_cycles", nb, 32'd0);
    chk("flush_hi", hi, 32'd0);
    chk("flush_lo", lo, 32'h8000_0000);

    // Flush on the third busy cycle of a running mult must not abort it.
    wait_idle();
    @(posedge clk); #1;
    md_op = MD_MULT; rs_val = 32'd3; rt_val = 32'd5;
    @(posedge clk); #1;
    md_op = MD_NONE;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_idle();
    @(negedge clk);
    chk("runflush_hi", hi, 32'd0);
    chk("runflush_lo", lo, 32'd15);

    run_op(MD_MTHI, 32'h1234_5678, 32'd0, 1'b0, nb, st);
    chk("mthi_start", {31'd0, st}, 32'd0);
    chk("mthi_busy", nb, 32'd0);
    chk("mthi_hi", hi, 32'h1234_5678);

    run_op(MD_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b1, nb, st);
    chk("mtlo_flush_lo", lo, 32'd15);

    // Asynchronous reset in the 4th busy cycle of a div.
    wait_idle();
    @(posedge clk); #1;
    md_op = MD_DIV; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk); #1;
    md_op = MD_NONE;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;

    run_op(MD_MULT, 32'd6, 32'd7, 1'b0, nb, st);
    chk("postrst_busy_cycles", nb, 32'd5);
    chk("postrst_hi", hi, 32'd0);
    chk("postrst_lo", lo, 32'd42);

    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      flush  = ($urandom_range(0, 7) == 0);
      rs_val = rand_val();
      rt_val = ($urandom_range(0, 7) == 0) ? 32'd0 : rand_val();
      if (m_rem == 0 && $urandom_range(0, 2) != 0) md_op = 4'($urandom_range(1, 6));
      else md_op = MD_NONE;
    end
    @(posedge clk); #1;
    md_op = MD_NONE; flush = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
